// File: rtl/hue_sequencer.sv
// Hue-wheel sweep generator: produces R/G/B duty words for three PWM channels,
// walking six linear segments (red->yellow->green->cyan->blue->magenta->red).
module hue_sequencer #(
  parameter  int PWM_INTERVAL = 1000,
  parameter  int STEP_CYCLES  = 2000,
  localparam int W            = $clog2(PWM_INTERVAL),
  localparam int PW           = $clog2(STEP_CYCLES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  output logic [W-1:0] r_value,
  output logic [W-1:0] g_value,
  output logic [W-1:0] b_value,
  output logic [2:0]   segment,
  output logic         step_pulse,
  output logic         cycle_done
);

  localparam logic [W-1:0]  MAX        = W'(PWM_INTERVAL - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  ramp_q, ramp_d;
  logic [2:0]    seg_q, seg_d;
  logic [W-1:0]  r_value_q, r_value_d;
  logic [W-1:0]  g_value_q, g_value_d;
  logic [W-1:0]  b_value_q, b_value_d;
  logic          step_pulse_q, step_pulse_d;
  logic          cycle_done_q, cycle_done_d;

  logic          step;
  logic          illegal;
  logic [W-1:0]  up;
  logic [W-1:0]  dn;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      ramp_q       <= '0;
      seg_q        <= S0;
      r_value_q    <= MAX;
      g_value_q    <= '0;
      b_value_q    <= '0;
      step_pulse_q <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      ramp_q       <= ramp_d;
      seg_q        <= seg_d;
      r_value_q    <= r_value_d;
      g_value_q    <= g_value_d;
      b_value_q    <= b_value_d;
      step_pulse_q <= step_pulse_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Next state: prescaler, ramp and segment FSM
  always_comb begin
    step    = enable && (presc_q == PRESC_LAST);
    illegal = (seg_q > S5);
    presc_d = presc_q;
    ramp_d  = ramp_q;
    seg_d   = seg_q;
    if (enable) begin
      presc_d = step ? '0 : presc_q + 1'b1;
    end
    // An unreachable encoding recovers to the start of the wheel regardless of enable.
    if (illegal) begin
      seg_d  = S0;
      ramp_d = '0;
    end else if (step) begin
      if (ramp_q == MAX) begin
        ramp_d = '0;
        seg_d  = (seg_q == S5) ? S0 : seg_q + 3'd1;
      end else begin
        ramp_d = ramp_q + 1'b1;
      end
    end
  end

  // Outputs: decode the next-state so words update on the same edge as ramp/segment
  always_comb begin
    up           = ramp_d;
    dn           = MAX - ramp_d;
    step_pulse_d = step && !illegal;
    cycle_done_d = step && !illegal && (seg_q == S5) && (ramp_q == MAX);
    r_value_d    = MAX;
    g_value_d    = '0;
    b_value_d    = '0;
    case (seg_d)
      S0:      begin r_value_d = MAX; g_value_d = up;  b_value_d = '0;  end
      S1:      begin r_value_d = dn;  g_value_d = MAX; b_value_d = '0;  end
      S2:      begin r_value_d = '0;  g_value_d = MAX; b_value_d = up;  end
      S3:      begin r_value_d = '0;  g_value_d = dn;  b_value_d = MAX; end
      S4:      begin r_value_d = up;  g_value_d = '0;  b_value_d = MAX; end
      S5:      begin r_value_d = MAX; g_value_d = '0;  b_value_d = dn;  end
      default: begin r_value_d = MAX; g_value_d = '0;  b_value_d = '0;  end
    endcase
  end

  assign r_value    = r_value_q;
  assign g_value    = g_value_q;
  assign b_value    = b_value_q;
  assign segment    = seg_q;
  assign step_pulse = step_pulse_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Directed bench for hue_sequencer with PWM_INTERVAL=4 (MAX=3) and STEP_CYCLES=3.
module tb_hue_sequencer;

  localparam int PI = 4;
  localparam int SC = 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] r_value;
  logic [1:0] g_value;
  logic [1:0] b_value;
  logic [2:0] segment;
  logic       step_pulse;
  logic       cycle_done;

  int total = 0;
  int bad   = 0;

  hue_sequencer #(.PWM_INTERVAL(PI), .STEP_CYCLES(SC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .r_value    (r_value),
    .g_value    (g_value),
    .b_value    (b_value),
    .segment    (segment),
    .step_pulse (step_pulse),
    .cycle_done (cycle_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input int r, input int g, input int b);
    check({tag, "_r"}, 32'(r_value), 32'(r));
    check({tag, "_g"}, 32'(g_value), 32'(g));
    check({tag, "_b"}, 32'(b_value), 32'(b));
  endtask

  task automatic check_all(input string tag, input int r, input int g, input int b,
                           input int seg, input int sp, input int cd);
    check_rgb(tag, r, g, b);
    check({tag, "_seg"}, 32'(segment), 32'(seg));
    check({tag, "_step"}, 32'(step_pulse), 32'(sp));
    check({tag, "_done"}, 32'(cycle_done), 32'(cd));
  endtask

  // Hue wheel table: returns {r,g,b} for a segment and ramp position, MAX=3
  function automatic void wheel(input int seg, input int rp, output int r, output int g, output int b);
    int up;
    int dn;
    up = rp;
    dn = 3 - rp;
    case (seg)
      0: begin r = 3;  g = up; b = 0;  end
      1: begin r = dn; g = 3;  b = 0;  end
      2: begin r = 0;  g = 3;  b = up; end
      3: begin r = 0;  g = dn; b = 3;  end
      4: begin r = up; g = 0;  b = 3;  end
      default: begin r = 3; g = 0; b = dn; end
    endcase
  endfunction

  initial begin
    int er, eg, eb;
    int pr, pg, pb;
    int k, nchg;
    logic sp;

    // Reset held two cycles with enable high
    reset  = 1'b1;
    enable = 1'b1;
    tick();
    check_all("rst1", 3, 0, 0, 0, 0, 0);
    tick();
    check_all("rst2", 3, 0, 0, 0, 0, 0);

    // Full revolution with enable held high; edge e counts from reset release
    reset = 1'b0;
    pr = 3; pg = 0; pb = 0;
    for (int e = 1; e <= 72; e++) begin
      tick();
      k  = e / SC;
      sp = (e % SC) == 0;
      wheel((k / 4) % 6, k % 4, er, eg, eb);
      check_all($sformatf("sweep_e%0d", e), er, eg, eb, (k / 4) % 6,
                int'(sp), int'(sp && (k % 24) == 0));
      nchg = int'(r_value != 2'(pr)) + int'(g_value != 2'(pg)) + int'(b_value != 2'(pb));
      if (sp && (k % 4) != 0) check($sformatf("onechg_e%0d", e), 32'(nchg), 32'd1);
      else                    check($sformatf("nochg_e%0d", e), 32'(nchg), 32'd0);
      pr = int'(r_value); pg = int'(g_value); pb = int'(b_value);
      if (e == 3)  check_all("first_step", 3, 1, 0, 0, 1, 0);
      if (e == 12) check_all("seg1_entry", 3, 3, 0, 1, 1, 0);
      if (e == 15) check_rgb("seg1_step1", 2, 3, 0);
      if (e == 24) check_all("seg2_entry", 0, 3, 0, 2, 1, 0);
      if (e == 60) check_all("seg5_entry", 3, 0, 3, 5, 1, 0);
      if (e == 72) check_all("wrap", 3, 0, 0, 0, 1, 1);
    end
    tick();
    check_all("wrap_after", 3, 0, 0, 0, 0, 0);

    // Pause: presc=1 after edge 4, then enable low for 10 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    check_all("pause_pre", 3, 1, 0, 0, 0, 0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("paused_%0d", i), 3, 1, 0, 0, 0, 0);
    end
    enable = 1'b1;
    tick();
    check_all("resume1", 3, 1, 0, 0, 0, 0);
    tick();
    check_all("resume2_step", 3, 2, 0, 0, 1, 0);
    tick();
    check_all("resume3", 3, 2, 0, 0, 0, 0);

    // Reset mid-sweep at edge 40 (S3, ramp 1)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 40; e++) tick();
    check_all("mid_e40", 0, 2, 3, 3, 0, 0);
    reset = 1'b1;
    tick();
    check_all("mid_rst", 3, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("post_rst1", 3, 0, 0, 0, 0, 0);
    tick();
    check_all("post_rst2", 3, 0, 0, 0, 0, 0);
    tick();
    check_all("post_rst3_step", 3, 1, 0, 0, 1, 0);

    // Reset landing on a step edge suppresses the strobe
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all("rst_on_step", 3, 0, 0, 0, 0, 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hue_sequencer.md
# hue_sequencer

Generates the three duty-cycle words that drive the RGB `pwm` channels, sweeping the LED smoothly through the full hue wheel. The sweep has six linear segments (red→yellow→green→cyan→blue→magenta→red). The block sits directly upstream of three `pwm` instances. It feeds each one's `pwm_value` and runs on the same 12 MHz `clk`.

## Interface
- `PWM_INTERVAL`, default 1000: downstream PWM period in clocks. Sets `MAX = PWM_INTERVAL-1` and the duty-word width `W = $clog2(PWM_INTERVAL)`. Must be ≥2.
- `STEP_CYCLES`, default 2000: enabled clocks per ramp step. Must be ≥2. The defaults give 6·1000·2000 = 12 M clocks, i.e. 1 s per hue revolution.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset. It has priority over everything else.
- `enable`  in  1: when high, the prescaler advances; when low, all state holds.
- `r_value`  out  W: red duty word, goes to the red `pwm` `pwm_value`.
- `g_value`  out  W: green duty word.
- `b_value`  out  W: blue duty word.
- `segment`  out  3: current hue segment, 0–5.
- `step_pulse`  out  1: one-cycle strobe marking a ramp advance.
- `cycle_done`  out  1: one-cycle strobe marking the wrap from segment 5 to 0.

## Operation
- State registers:
  - `presc`, width `$clog2(STEP_CYCLES)`, counts 0..STEP_CYCLES-1.
  - `ramp`, width W, counts 0..MAX.
  - `segment`, a 6-state FSM S0..S5.
- Step event: occurs when `enable` is high and `presc == STEP_CYCLES-1`. On a step, `presc` goes to 0. Otherwise, with `enable` high, `presc` increments.
- On a step:
  - If `ramp < MAX`, `ramp` increments.
  - If `ramp == MAX`, `ramp` goes to 0 and `segment` advances S0→S1→…→S5→S0.
- Decode, with `up = ramp` and `dn = MAX - ramp` (`ramp ≤ MAX`, so no underflow):
  - S0: R=MAX, G=up, B=0
  - S1: R=dn, G=MAX, B=0
  - S2: R=0, G=MAX, B=up
  - S3: R=0, G=dn, B=MAX
  - S4: R=up, G=0, B=MAX
  - S5: R=MAX, G=0, B=dn
- Continuity: the last word of each segment equals the first word of the next (e.g. S0 end R=MAX, G=MAX matches S1 start). A segment crossing therefore produces no jump on any channel.
- `segment` encodings 6 and 7 are unreachable. If one is ever present, the next edge forces S0 with `ramp`=0.
- `enable` low: `presc`, `ramp`, `segment` and all value outputs hold; both strobes are 0. `presc` is not cleared, so the partial step resumes when `enable` returns high.
- Downstream comparator semantics are not compensated: a value of 0 still yields a 1/PWM_INTERVAL duty in `pwm`.

## Timing
- All outputs are registered. `r/g/b_value` are computed from next-state, so they change on the same edge that updates `ramp`/`segment`.
- Reset values: `presc`=0, `ramp`=0, `segment`=0, `r_value`=MAX, `g_value`=0, `b_value`=0, `step_pulse`=0, `cycle_done`=0.
- `step_pulse` is high for exactly the one cycle in which the new ramp/segment/value words first appear.
- `cycle_done` is high in that same cycle only for the S5→S0 wrap. It always coincides with `step_pulse`.
- With `enable` held high from reset release, edge 1 being the first post-reset edge:
  - The first step lands on edge STEP_CYCLES.
  - Segment n is entered at edge n·STEP_CYCLES·PWM_INTERVAL.
  - The full revolution completes at edge 6·STEP_CYCLES·PWM_INTERVAL.
- Reset asserted mid-operation, including on a step edge: the next edge loads the reset values and no strobe fires.
- Latency from `enable` rising to its first counted cycle is 0. The edge on which `enable` is sampled high advances `presc`.

## Test plan
All scenarios use PWM_INTERVAL=4 (MAX=3, W=2) and STEP_CYCLES=3.
- Reset: hold `reset` for 2 cycles with `enable`=1 → r/g/b = 3/0/0, `segment`=0, both strobes 0, outputs unchanged while `reset` is high.
- First steps: release `reset`, `enable`=1 → after edge 3: g=1, `step_pulse`=1 for one cycle. Edge 6: g=2. Edge 9: g=3. r stays 3, b stays 0.
- Segment walk: continue `enable`=1 → edge 12: `segment`=1, r/g/b=3/3/0. Edge 15: 2/3/0. Edge 24: `segment`=2, 0/3/0. Check every step against the decode rules, with exactly one channel changing per step.
- Revolution wrap: continue to edge 72 → `segment`=0, r/g/b=3/0/0, `cycle_done`=1 and `step_pulse`=1 for exactly that one cycle. Edge 60 (S5 entry) shows 3/0/3.
- Pause: after edge 4 (`presc`=1), drop `enable` for 10 cycles → all outputs frozen, no strobes. Re-raise it → the next step occurs after exactly 2 more enabled edges.
- Reset mid-sweep: assert `reset` at edge 40 (within S3) → the following edge shows 3/0/0 with `segment`=0. After release, the first step again takes 3 edges.
